// File: rtl/tile_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tile_draw_arbiter
//
// Shares the single vga_adapter pixel-write port between N_REQ sprite
// requesters (Pac-Man, ghosts, pellet/score updaters). Each requester asks
// for one 5x5 tile to be drawn or erased at a grid coordinate. The arbiter
// picks a winner round-robin, latches its request and then writes the 25
// pixels in row-major order, one per clock.
//
// Ports
//   clock       : system clock (CLOCK_50 domain)
//   reset_n     : asynchronous active-low reset
//   req         : level request per requester, held until its grant is seen
//   req_gx      : packed 5-bit grid column per requester (slice i = [5i+4:5i])
//   req_gy      : packed 5-bit grid row per requester
//   req_shape   : packed 25-bit bitmap per requester, bit 24 = top-left pixel
//   req_colour  : packed 3-bit colour per requester
//   req_erase   : 1 = write black to all 25 pixels
//   grant       : one-hot 1-cycle pulse in the first cycle of a tile
//   done        : one-hot 1-cycle pulse after the last pixel of a tile
//   busy        : high whenever the arbiter is not idle
//   plot_en     : pixel write strobe to vga_adapter
//   x_out/y_out : pixel coordinate
//   colour_out  : pixel colour
// -----------------------------------------------------------------------------
module tile_draw_arbiter #(
    parameter int N_REQ  = 4,
    parameter int GRID_H = 24
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [5*N_REQ-1:0]   req_gx,
    input  logic [5*N_REQ-1:0]   req_gy,
    input  logic [25*N_REQ-1:0]  req_shape,
    input  logic [3*N_REQ-1:0]   req_colour,
    input  logic [N_REQ-1:0]     req_erase,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 busy,
    output logic                 plot_en,
    output logic [7:0]           x_out,
    output logic [6:0]           y_out,
    output logic [2:0]           colour_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Colour of one pixel: erase forces black, a clear bitmap bit also writes
    // black (tiles are opaque, never transparent).
    function automatic logic [2:0] pix_colour(
        input logic [24:0] shape,
        input logic [2:0]  colour,
        input logic        erase,
        input logic [4:0]  idx
    );
        logic [4:0] bit_idx;
        logic [2:0] result;
        bit_idx = 5'd24 - idx;
        if (erase) begin
            result = 3'd0;
        end else if (shape[bit_idx]) begin
            result = colour;
        end else begin
            result = 3'd0;
        end
        return result;
    endfunction

    // Requester index visited k steps after 'last', wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] rr_idx(
        input logic [IDX_W-1:0] last,
        input int               k
    );
        int s;
        s = int'(last) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end else begin
            s = s;
        end
        return IDX_W'(s);
    endfunction

    state_t             state_q;
    logic [IDX_W-1:0]   last_q;
    logic [7:0]         bx_q;
    logic [6:0]         by_q;
    logic [24:0]        shape_q;
    logic [2:0]         colour_q;
    logic               erase_q;
    logic               offscreen_q;
    logic [2:0]         col_q;
    logic [2:0]         row_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   done_q;
    logic               busy_q;
    logic               plot_en_q;
    logic [7:0]         x_q;
    logic [6:0]         y_q;
    logic [2:0]         colour_out_q;

    logic               found_d;
    logic [IDX_W-1:0]   win_d;
    logic [4:0]         sel_gx_d;
    logic [4:0]         sel_gy_d;
    logic [24:0]        sel_shape_d;
    logic [2:0]         sel_colour_d;
    logic               sel_erase_d;
    logic [7:0]         sel_bx_d;
    logic [6:0]         sel_by_d;
    logic               sel_off_d;
    logic [2:0]         col_d;
    logic [2:0]         row_d;
    logic [4:0]         pix_idx_d;

    // Round-robin winner search starting just after the last served requester.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found_d && req[rr_idx(last_q, k)]) begin
                found_d = 1'b1;
                win_d   = rr_idx(last_q, k);
            end else begin
                found_d = found_d;
            end
        end
    end

    // Select the winner's request fields and precompute its tile origin.
    always_comb begin
        sel_gx_d     = 5'd0;
        sel_gy_d     = 5'd0;
        sel_shape_d  = 25'd0;
        sel_colour_d = 3'd0;
        sel_erase_d  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_d == IDX_W'(i)) begin
                sel_gx_d     = req_gx[5*i +: 5];
                sel_gy_d     = req_gy[5*i +: 5];
                sel_shape_d  = req_shape[25*i +: 25];
                sel_colour_d = req_colour[3*i +: 3];
                sel_erase_d  = req_erase[i];
            end else begin
                sel_erase_d  = sel_erase_d;
            end
        end
        // 31*5 = 155 fits in 8 bits; y wraps modulo 128 only for offscreen rows.
        sel_bx_d  = {3'b000, sel_gx_d} * 8'd5;
        sel_by_d  = {2'b00, sel_gy_d} * 7'd5;
        sel_off_d = (int'({27'd0, sel_gy_d}) >= GRID_H);
    end

    // Next pixel position inside the tile (row-major walk).
    always_comb begin
        if (col_q == 3'd4) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
        end else begin
            col_d = col_q + 3'd1;
            row_d = row_q;
        end
        pix_idx_d = ({2'b00, row_d} * 5'd5) + {2'b00, col_d};
    end

    // Main FSM: accept in IDLE, stream 25 pixels in DRAW, pulse done in DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_q       <= IDX_W'(N_REQ - 1);
            bx_q         <= 8'd0;
            by_q         <= 7'd0;
            shape_q      <= 25'd0;
            colour_q     <= 3'd0;
            erase_q      <= 1'b0;
            offscreen_q  <= 1'b0;
            col_q        <= 3'd0;
            row_q        <= 3'd0;
            grant_q      <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            plot_en_q    <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_out_q <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= '0;
                    if (found_d) begin
                        // Pixel 0 is presented in the same cycle as grant.
                        state_q      <= S_DRAW;
                        last_q       <= win_d;
                        bx_q         <= sel_bx_d;
                        by_q         <= sel_by_d;
                        shape_q      <= sel_shape_d;
                        colour_q     <= sel_colour_d;
                        erase_q      <= sel_erase_d;
                        offscreen_q  <= sel_off_d;
                        col_q        <= 3'd0;
                        row_q        <= 3'd0;
                        grant_q      <= N_REQ'(1) << win_d;
                        busy_q       <= 1'b1;
                        plot_en_q    <= !sel_off_d;
                        x_q          <= sel_bx_d;
                        y_q          <= sel_by_d;
                        colour_out_q <= pix_colour(sel_shape_d, sel_colour_d,
                                                   sel_erase_d, 5'd0);
                    end else begin
                        state_q      <= S_IDLE;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                        plot_en_q    <= 1'b0;
                    end
                end
                S_DRAW: begin
                    grant_q <= '0;
                    if ((row_q == 3'd4) && (col_q == 3'd4)) begin
                        state_q      <= S_DONE;
                        done_q       <= N_REQ'(1) << last_q;
                        plot_en_q    <= 1'b0;
                        x_q          <= 8'd0;
                        y_q          <= 7'd0;
                        colour_out_q <= 3'd0;
                    end else begin
                        state_q      <= S_DRAW;
                        col_q        <= col_d;
                        row_q        <= row_d;
                        plot_en_q    <= !offscreen_q;
                        x_q          <= bx_q + {5'd0, col_d};
                        y_q          <= by_q + {4'd0, row_d};
                        colour_out_q <= pix_colour(shape_q, colour_q, erase_q,
                                                   pix_idx_d);
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    done_q    <= '0;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    plot_en_q <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    grant_q      <= '0;
                    done_q       <= '0;
                    busy_q       <= 1'b0;
                    plot_en_q    <= 1'b0;
                    x_q          <= 8'd0;
                    y_q          <= 7'd0;
                    colour_out_q <= 3'd0;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign plot_en    = plot_en_q;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = colour_out_q;

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for tile_draw_arbiter. A behavioural model expands every accepted
// request into the list of per-cycle outputs it must produce (grant + 25
// pixels, done, idle) and compares the DUT against that list each cycle.
// -----------------------------------------------------------------------------
module tb_tile_draw_arbiter;

    localparam int N      = 4;
    localparam int GRID_H = 24;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [5*N-1:0]   req_gx;
    logic [5*N-1:0]   req_gy;
    logic [25*N-1:0]  req_shape;
    logic [3*N-1:0]   req_colour;
    logic [N-1:0]     req_erase;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic             busy;
    logic             plot_en;
    logic [7:0]       x_out;
    logic [6:0]       y_out;
    logic [2:0]       colour_out;

    tile_draw_arbiter #(.N_REQ(N), .GRID_H(GRID_H)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .req_gx     (req_gx),
        .req_gy     (req_gy),
        .req_shape  (req_shape),
        .req_colour (req_colour),
        .req_erase  (req_erase),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .plot_en    (plot_en),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic         busy;
        logic         plot;
        logic         pix;
        logic [7:0]   x;
        logic [6:0]   y;
        logic [2:0]   col;
    } rec_t;

    rec_t  exp_q[$];
    rec_t  cur;
    int    m_last;
    bit    keep_req;
    bit    rnd_mode;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] gx, input logic [4:0] gy,
                           input logic [24:0] sh, input logic [2:0] co, input logic er);
        req[i]               = 1'b1;
        req_gx[5*i +: 5]     = gx;
        req_gy[5*i +: 5]     = gy;
        req_shape[25*i +: 25] = sh;
        req_colour[3*i +: 3] = co;
        req_erase[i]         = er;
    endtask

    // Expand an accepted request into its expected per-cycle outputs.
    task automatic model_accept();
        int          w;
        logic [4:0]  gx;
        logic [4:0]  gy;
        logic [24:0] sh;
        logic [2:0]  co;
        logic        er;
        rec_t        r;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        end
        m_last = w;
        gx = req_gx[5*w +: 5];
        gy = req_gy[5*w +: 5];
        sh = req_shape[25*w +: 25];
        co = req_colour[3*w +: 3];
        er = req_erase[w];
        for (int p = 0; p < 25; p++) begin
            r      = '0;
            r.busy = 1'b1;
            r.pix  = 1'b1;
            r.plot = (int'(gy) < GRID_H);
            r.x    = 8'(int'(gx) * 5 + p % 5);
            r.y    = 7'((int'(gy) * 5 + p / 5) % 128);
            r.col  = (er || !sh[24 - p]) ? 3'd0 : co;
            if (p == 0) r.grant = N'(1) << w;
            exp_q.push_back(r);
        end
        r      = '0;
        r.busy = 1'b1;
        r.done = N'(1) << w;
        exp_q.push_back(r);
        r = '0;
        exp_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clock);
        if (exp_q.size() == 0 && req != '0) model_accept();
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '0;
        @(negedge clock);
        chk("grant",   grant,   cur.grant);
        chk("done",    done,    cur.done);
        chk("busy",    busy,    cur.busy);
        chk("plot_en", plot_en, cur.plot);
        if (cur.pix) begin
            chk("x_out",      x_out,      cur.x);
            chk("y_out",      y_out,      cur.y);
            chk("colour_out", colour_out, cur.col);
        end
        for (int i = 0; i < N; i++) begin
            if (cur.grant[i] && !keep_req) req[i] = 1'b0;
            if (rnd_mode) begin
                if (!req[i] && $urandom_range(0, 3) == 0)
                    set_req(i, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                            25'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0));
                else if (req[i] && $urandom_range(0, 99) == 0)
                    req[i] = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   grant,   '0);
        chk({tag, "_done"},    done,    '0);
        chk({tag, "_busy"},    busy,    1'b0);
        chk({tag, "_plot_en"}, plot_en, 1'b0);
        chk({tag, "_x_out"},   x_out,   8'd0);
    endtask

    // Async reset pulse: outputs must clear at once, model forgets everything.
    task automatic pulse_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 chk_all_zero(tag);
        exp_q.delete();
        m_last = N - 1;
        cur    = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        req        = '0;
        req_gx     = '0;
        req_gy     = '0;
        req_shape  = '0;
        req_colour = '0;
        req_erase  = '0;
        keep_req   = 1'b0;
        rnd_mode   = 1'b0;
        m_last     = N - 1;
        cur        = '0;

        @(negedge clock);
        chk_all_zero("reset");
        chk("reset_y",      y_out,      7'd0);
        chk("reset_colour", colour_out, 3'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Full solid tile, erase, corners-only and offscreen tiles.
        set_req(0, 5'd2, 5'd3, 25'h1FFFFFF, 3'b110, 1'b0);
        run(30);
        set_req(0, 5'd2, 5'd3, 25'h1FFFFFF, 3'b110, 1'b1);
        run(30);
        set_req(1, 5'd31, 5'd23, 25'h1000001, 3'b011, 1'b0);
        run(30);
        set_req(3, 5'd0, 5'd24, 25'h1FFFFFF, 3'b111, 1'b0);
        run(30);

        // All four requesters held high: rotation 0..3 and back.
        keep_req = 1'b1;
        for (int i = 0; i < N; i++)
            set_req(i, 5'(i * 3), 5'(i + 5), 25'(32'h0155_AA33 >> i), 3'(i + 1), 1'b0);
        run(5 * 27 + 3);
        keep_req = 1'b0;
        req      = '0;
        run(30);

        // Reset at pixel 12, then requester 0 wins over 2 after release.
        set_req(1, 5'd7, 5'd9, 25'h0ABCDEF, 3'b101, 1'b0);
        run(13);
        req = '0;
        set_req(0, 5'd4, 5'd4, 25'h1F00000, 3'b001, 1'b0);
        set_req(2, 5'd6, 5'd6, 25'h000001F, 3'b010, 1'b0);
        pulse_reset("abort");
        run(60);

        // Reset mid-tile again, only requester 2 present.
        set_req(3, 5'd1, 5'd1, 25'h1FFFFFF, 3'b100, 1'b0);
        run(13);
        req = '0;
        set_req(2, 5'd9, 5'd2, 25'h1555555, 3'b110, 1'b0);
        pulse_reset("abort2");
        run(30);

        // Randomized traffic.
        rnd_mode = 1'b1;
        run(3000);
        rnd_mode = 1'b0;
        req      = '0;
        run(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tile_draw_arbiter.md
Name: tile_draw_arbiter

Overview:
- Shares the single VGA pixel-write port between N sprite requesters: Pac-Man, ghosts and pellet/score updaters.
- Each requester asks for one 5x5 tile to be drawn or erased at a grid coordinate.
- The block grants requests round-robin and latches the request.
- It then sequences the 25 pixel writes (row-major) onto plot_en/x_out/y_out/colour_out, which feed vga_adapter directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GRID_H, 24, number of valid grid rows. Rows at or above this value are off-screen.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester. Held high until that requester's grant bit is seen.
- req_gx  in  5*N_REQ  packed grid column per requester. Slice i is [5i+4:5i].
- req_gy  in  5*N_REQ  packed grid row per requester.
- req_shape  in  25*N_REQ  packed 5x5 bitmap. Bit 24 of each slice is the top-left pixel; row-major order.
- req_colour  in  3*N_REQ  packed 3-bit colour.
- req_erase  in  N_REQ  1 = write black to all 25 pixels.
- grant  out  N_REQ  one-hot, 1-cycle pulse. Marks the cycle after the request was accepted.
- done  out  N_REQ  one-hot, 1-cycle pulse after the last pixel of that requester's tile.
- busy  out  1  high whenever state is not IDLE.
- plot_en  out  1  pixel write strobe to vga_adapter.
- x_out  out  8  pixel x.
- y_out  out  7  pixel y.
- colour_out  out  3  pixel colour.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: all outputs are 0; state = IDLE; round-robin pointer last = N_REQ-1, so requester 0 has first priority.
- Reset mid-operation: asserting reset_n low during DRAW aborts the tile. plot_en drops asynchronously, no done pulse is produced, and no pending request is remembered.
- All outputs are registered.
- State IDLE:
  - If req != 0, select winner w = first i with req[i]=1, scanning (last+1) mod N_REQ upward with wrap.
  - On that edge: latch bx = gx_w*5 (8 bits, max 155), by = gy_w*5 (7 bits), shape_w, colour_w, erase_w; set offscreen = (gy_w >= GRID_H); set last = w; zero the pixel counter (col 0..4, row 0..4).
  - Go to DRAW; grant[w] = 1 for the next cycle only.
  - If req == 0, stay in IDLE.
- State DRAW: exactly 25 cycles, one pixel per cycle.
  - plot_en = !offscreen.
  - x_out = bx+col.
  - y_out = by+row.
  - colour_out = erase ? 0 : (shape[24-(5*row+col)] ? colour : 0). A 0 bitmap bit writes black; it is not transparent.
  - col increments 0..4. At col=4, col wraps to 0 and row increments.
  - At row=4, col=4, the next state is DONE.
- State DONE: one cycle; plot_en = 0; done[w] = 1; next state is IDLE.
- Latency: from the IDLE sampling edge, grant appears in cycle +1, pixels in cycles +1..+25, done in cycle +26, and IDLE again in cycle +27. A back-to-back grant is therefore possible every 27 cycles.
- Request rules:
  - Requests are sampled only in IDLE.
  - Input fields may change freely after grant.
  - A requester that keeps req high after done is served again, but only after every other pending requester (fairness).
- Simultaneous events:
  - Requests arriving during DRAW/DONE wait.
  - A request that is dropped before grant is lost without error.
- Offscreen tiles (gy >= GRID_H) are still granted and run all 25 counted cycles with plot_en = 0, then pulse done. This keeps requester timing uniform.
- Arithmetic: gx <= 31 gives x <= 159. by is computed modulo 128 when offscreen; the value is irrelevant because plot_en is 0.
- busy = (state != IDLE).

Test Plan:
- Reset, then req=4'b0001, gx=2, gy=3, shape=25'h1FFFFFF, colour=3'b110, erase=0 -> grant=0001 one cycle later. Then 25 plot_en cycles with (x,y) running (10,15),(11,15)..(14,15),(10,16)..(14,19), all with colour 110. done=0001 in cycle +26.
- Same request with erase=1 -> 25 pixels, all colour_out=000.
- Shape 25'h1000001 (corners only), colour 3'b011 -> colour 011 only at pixel 0 (bx,by) and pixel 24 (bx+4,by+4); the other 23 pixels are 000.
- req=4'b1111 held continuously -> grants in order 0,1,2,3,0, spaced 27 cycles apart. Pixel writes from different tiles never overlap.
- gy=24 with gx=0 -> grant, 25 cycles with plot_en=0, done pulses, busy low in cycle +27.
- Pull reset_n low at pixel 12 of a tile -> plot_en, busy, grant and done go 0 immediately. After release, req[2] alone is granted before req[0] only if req[0] is absent (last pointer back to N_REQ-1).
